result_stream_fifo: RTL

//  Downstream stage of Batch_top. Captures the per-cycle float result word, buffers it
//  in a FIFO and drains it over a valid/ready stream toward the host/capture interface.

---
 rtl/result_stream_fifo.sv | 119 +++++++++++
 1 files changed

// File: rtl/result_stream_fifo.sv
// Result-word FIFO with sequence tagging, a registered output stage and a valid/ready drain.
// Samples that arrive while the FIFO is full are counted and flagged as overflow.
module result_stream_fifo #(
    parameter  int DW     = 32,
    parameter  int DEPTH  = 16,
    parameter  int SEQ_W  = 16,
    parameter  int DROP_W = 8,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int LVL_W  = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DW-1:0]     in,
    input  logic              in_valid,
    output logic [DW-1:0]     out_data,
    output logic [SEQ_W-1:0]  out_seq,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LVL_W-1:0]  level,
    output logic              overflow,
    output logic [DROP_W-1:0] drop_cnt
);

    logic [DW+SEQ_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [SEQ_W-1:0]  seq_q, seq_d;
    logic              overflow_q, overflow_d;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
    logic              out_valid_q, out_valid_d;
    logic [DW-1:0]     out_data_q, out_data_d;
    logic [SEQ_W-1:0]  out_seq_q, out_seq_d;

    logic              pop, push, full, load;
    logic [LVL_W-1:0]  mem_cnt;
    logic [DW+SEQ_W-1:0] head_word;

    always_comb begin
        pop       = out_valid_q & out_ready;
        full      = (level_q == LVL_W'(DEPTH));
        push      = in_valid & (~full | pop);
        // level counts the output register too; mem_cnt is what still sits in storage
        mem_cnt   = level_q - LVL_W'(out_valid_q);
        load      = (mem_cnt != '0) & (~out_valid_q | pop);
        head_word = mem[rd_ptr_q];

        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        seq_d       = seq_q;
        overflow_d  = overflow_q;
        drop_cnt_d  = drop_cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_seq_d   = out_seq_q;
        level_d     = level_q + LVL_W'(push) - LVL_W'(pop);

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (load) begin
            rd_ptr_d    = rd_ptr_q + 1'b1;
            out_valid_d = 1'b1;
            out_data_d  = head_word[DW+SEQ_W-1:SEQ_W];
            out_seq_d   = head_word[SEQ_W-1:0];
        end else if (pop) begin
            out_valid_d = 1'b0;
        end
        if (in_valid) begin
            seq_d = seq_q + 1'b1;
            if (!push) begin
                overflow_d = 1'b1;
                if (drop_cnt_q != '1) begin
                    drop_cnt_d = drop_cnt_q + 1'b1;
                end
            end
        end
    end

    // storage has no reset so it can map onto RAM
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= {in, seq_q};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            seq_q       <= '0;
            overflow_q  <= 1'b0;
            drop_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_seq_q   <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            seq_q       <= seq_d;
            overflow_q  <= overflow_d;
            drop_cnt_q  <= drop_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_seq_q   <= out_seq_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_seq   = out_seq_q;
    assign out_valid = out_valid_q;
    assign level     = level_q;
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_cnt_q;

endmodule
